// File: rtl/busarb_pkg.sv
// Shared types and width helpers for the round-robin bus arbiter.
package busarb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StTurn
  } state_e;

  function automatic int unsigned ptr_width(input int unsigned n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  function automatic int unsigned hold_width(input int unsigned max_hold);
    return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
  endfunction

endpackage

// File: rtl/busarb_rr_pick.sv
// Rotate-priority picker: first asserted request at or after ptr, wrapping modulo N_REQ.
module busarb_rr_pick
  import busarb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]            req,
  input  logic [ptr_width(N_REQ)-1:0] ptr,
  output logic                        any,
  output logic [ptr_width(N_REQ)-1:0] idx
);

  localparam int unsigned PW = ptr_width(N_REQ);

  logic [PW-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int i = 0; i < int'(N_REQ); i++) begin
      cand = PW'((int'(ptr) + i) % int'(N_REQ));
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/busarb_rr_ctrl.sv
// Round-robin owner of a shared registered bus with a one-cycle turnaround between owners.
// Define BUSARB_HOLD_LIMIT_EN to force release after MAX_HOLD grant cycles while others wait.
module busarb_rr_ctrl
  import busarb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               ck,
  input  logic               nrst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] data_i,
  output logic [N_REQ-1:0]   gnt,
  output logic [W-1:0]       q,
  output logic               q_vld,
  output logic               busy
);

  localparam int unsigned PW = ptr_width(N_REQ);

  if (N_REQ < 2 || MAX_HOLD < 1) begin : g_bad_params
    $error("busarb_rr_ctrl: need N_REQ >= 2 and MAX_HOLD >= 1");
  end

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [W-1:0]     q_q, q_d;
  logic             q_vld_q, q_vld_d;
  logic             busy_q;

  logic             pick_any;
  logic [PW-1:0]    pick_idx;
  logic [W-1:0]     own_data;
  logic             own_req;
  logic             hold_fire;
  logic             release_bus;

  busarb_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req(req),
    .ptr(ptr_q),
    .any(pick_any),
    .idx(pick_idx)
  );

  // gnt_q is one-hot of the owner throughout GRANT, so it doubles as the owner mask.
  assign own_req     = |(req & gnt_q);
  assign release_bus = !own_req || hold_fire;

  always_comb begin
    own_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (owner_q == PW'(k)) begin
        own_data = data_i[k*W +: W];
      end
    end
  end

`ifdef BUSARB_HOLD_LIMIT_EN
  localparam int unsigned HW = hold_width(MAX_HOLD);
  localparam logic [HW-1:0] HoldMax = HW'(MAX_HOLD);

  logic [HW-1:0] hold_q, hold_d;

  assign hold_fire = (hold_q == HoldMax) && |(req & ~gnt_q);

  always_comb begin
    hold_d = hold_q;
    if (state_q == StIdle && pick_any) begin
      hold_d = HW'(1);
    end else if (state_q == StGrant && hold_q != HoldMax) begin
      hold_d = hold_q + HW'(1);
    end
  end

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign hold_fire = 1'b0;
`endif

  // State register and all output/bookkeeping registers.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      q_q     <= '0;
      q_vld_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      q_q     <= q_d;
      q_vld_q <= q_vld_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_any) state_d = StGrant;
      StGrant: if (release_bus) state_d = StTurn;
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    q_d     = '0;
    q_vld_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          gnt_d   = N_REQ'(1) << pick_idx;
          owner_d = pick_idx;
        end
      end
      StGrant: begin
        // The exiting GRANT cycle still transfers owner data, hence the q_vld pulse on a
        // grant whose request has already gone away.
        q_d     = own_data;
        q_vld_d = 1'b1;
        if (release_bus) begin
          gnt_d = '0;
          ptr_d = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);
        end
      end
      default: gnt_d = '0;
    endcase
  end

  assign gnt   = gnt_q;
  assign q     = q_q;
  assign q_vld = q_vld_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_busarb_rr_ctrl.sv
// Directed bench for busarb_rr_ctrl (N_REQ=4, W=8, MAX_HOLD=3); covers both hold-limit builds.
module tb_busarb_rr_ctrl;

  localparam int unsigned N_REQ    = 4;
  localparam int unsigned W        = 8;
  localparam int unsigned MAX_HOLD = 3;

  logic               ck;
  logic               nrst;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] data_i;
  logic [N_REQ-1:0]   gnt;
  logic [W-1:0]       q;
  logic               q_vld;
  logic               busy;

  int checks = 0;
  int errors = 0;

  busarb_rr_ctrl #(
    .N_REQ(N_REQ),
    .W(W),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .ck(ck),
    .nrst(nrst),
    .req(req),
    .data_i(data_i),
    .gnt(gnt),
    .q(q),
    .q_vld(q_vld),
    .busy(busy)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic quick_reset();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
  endtask

  int cnt;
  logic [N_REQ-1:0] exp_gnt;

  initial begin
    // Slice 3..0 = 3C, A5, 5A, 11.
    data_i = {8'h3C, 8'hA5, 8'h5A, 8'h11};
    req    = '0;
    nrst   = 1'b0;

    // Reset holds everything quiet even with all requests up.
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("reset_quiet", {gnt, q, q_vld, busy}, '0);
    end
    req  = '0;
    nrst = 1'b1;
    tick();
    chk("idle_after_reset", {gnt, q_vld, busy}, '0);

    // Single requester 2 held for 5 grant cycles.
    req = 4'b0100;
    tick();
    chk("single_gnt", gnt, 4'b0100);
    chk("single_qvld_lag", q_vld, 1'b0);
    chk("single_busy", busy, 1'b1);
    tick();
    chk("single_q", {q, q_vld}, {8'hA5, 1'b1});
    tick(); tick(); tick();
    chk("single_hold_gnt", gnt, 4'b0100);
    req = '0;
    tick();
    chk("single_turn", {gnt, q_vld, busy}, {4'b0000, 1'b1, 1'b1});
    tick();
    chk("single_idle", {gnt, q, q_vld, busy}, '0);

    // Lone requester 1 for 40 cycles: no forced release in either build.
    req = 4'b0010;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (gnt == 4'b0010) cnt++;
    end
    chk("solo_hold_cycles", cnt, 40);
    chk("solo_q", {q, q_vld}, {8'h5A, 1'b1});
    req = '0;
    tick(); tick();
    chk("solo_done", busy, 1'b0);

    // Owner 3 in GRANT, then asynchronous reset between edges.
    req = 4'b1000;
    tick();
    chk("own3_gnt", gnt, 4'b1000);
    tick();
    chk("own3_q", {q, q_vld}, {8'h3C, 1'b1});
    #2 nrst = 1'b0;
    #1;
    chk("async_rst", {gnt, q, q_vld, busy}, '0);
    tick();
    nrst = 1'b1;
    req  = 4'b1010;
    tick();
    // A stale ptr would pick 3; after reset the search starts at 0.
    chk("post_rst_ptr0", gnt, 4'b0010);
    req = '0;
    tick(); tick();

    quick_reset();
`ifdef BUSARB_HOLD_LIMIT_EN
    // All requesting: 3 grant cycles each, 2 dead cycles, owners 0,1,2,3,0.
    req = 4'b1111;
    for (int n = 0; n < 25; n++) begin
      tick();
      exp_gnt = ((n % 5) < 3) ? (4'b0001 << ((n / 5) % 4)) : 4'b0000;
      chk("rotate_gnt", gnt, exp_gnt);
    end
    req = '0;
`else
    // No hold limit: owner 0 keeps the bus despite requester 1 waiting.
    req = 4'b0011;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (gnt == 4'b0001) cnt++;
    end
    chk("nolimit_keep", cnt, 30);
    req = 4'b0010;
    tick();
    chk("nolimit_turn", gnt, 4'b0000);
    tick();
    chk("nolimit_idle", {gnt, busy}, '0);
    tick();
    chk("nolimit_next", gnt, 4'b0010);
    req = '0;
`endif
    tick(); tick(); tick();
    chk("drained", {gnt, busy}, '0);

    // One-cycle request: one grant cycle, one q_vld pulse, then TURN and IDLE.
    req = 4'b0010;
    tick();
    req = '0;
    chk("short_gnt", {gnt, q_vld}, {4'b0010, 1'b0});
    tick();
    chk("short_turn", {gnt, q, q_vld, busy}, {4'b0000, 8'h5A, 1'b1, 1'b1});
    tick();
    chk("short_idle", {gnt, q, q_vld, busy}, '0);
    tick();
    chk("short_stay_idle", {gnt, q_vld, busy}, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
